// File: rtl/jk_counter_ctrl.sv
// jk_counter_ctrl: J/K sequencer for an external JK flip-flop counter bank.
// Optional auto-stop after one full pass: define JK_CTRL_AUTOSTOP_EN.
module jk_counter_ctrl #(
  parameter int N   = 3,
  parameter int MOD = 8
) (
  input  logic         CLK,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic         load,
  input  logic         clr,
  input  logic         dir,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] Q_in,
  output logic [N-1:0] J,
  output logic [N-1:0] K,
  output logic         busy,
  output logic         tc,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_LOAD,
    S_CLR,
    S_DONE
  } state_e;

  // Modulus may equal 2^N; range checks use one extra bit.
  localparam logic [N:0]   MODW = (N+1)'(MOD);
  localparam logic [N-1:0] TOP  = N'(MOD - 1);

  state_e       state_q, state_d;
  logic [N-1:0] ld_q, ld_d;
  logic [N-1:0] up_nxt, dn_nxt, nxt;
  logic         oor, tc_run;

  // Target value for one step in either direction.
  always_comb begin
    oor    = {1'b0, Q_in} >= MODW;
    up_nxt = (Q_in >= TOP) ? '0 : Q_in + N'(1);
    dn_nxt = (Q_in == '0 || oor) ? TOP : Q_in - N'(1);
    nxt    = dir ? up_nxt : dn_nxt;
    tc_run = dir ? (Q_in == TOP) : (Q_in == '0);
  end

  // Request arbitration: clr > load > stop > start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (clr)        state_d = S_CLR;
        else if (load)  state_d = S_LOAD;
        else if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (clr)       state_d = S_CLR;
        else if (load) state_d = S_LOAD;
        else if (stop) state_d = S_IDLE;
`ifdef JK_CTRL_AUTOSTOP_EN
        else if (tc_run) state_d = S_DONE;
`endif
      end
      S_LOAD:  state_d = S_IDLE;
      S_CLR:   state_d = S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Load value is latched on acceptance; out-of-range loads become 0.
  always_comb begin
    ld_d = ld_q;
    if (state_d == S_LOAD) begin
      ld_d = ({1'b0, load_val} >= MODW) ? '0 : load_val;
    end
  end

  // J/K drive: only bits that must change are set or reset.
  always_comb begin
    J = '0;
    K = '0;
    unique case (state_q)
      S_RUN: begin
        J = nxt & ~Q_in;
        K = ~nxt & Q_in;
      end
      S_LOAD: begin
        J = ld_q;
        K = ~ld_q;
      end
      S_CLR: begin
        K = '1;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign tc   = (state_q == S_RUN) && tc_run;

  // Sequencing state and captured load value.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
    end
  end

`ifdef JK_CTRL_AUTOSTOP_EN
  logic done_q;

  // One-cycle pulse while sitting in DONE.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_d == S_DONE);
    end
  end

  assign done = done_q;
`else
  assign done = 1'b0;
`endif

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// tb_jk_counter_ctrl: scoreboard bench, MOD=8 and MOD=6 controllers
// each driving its own behavioural JK bank from shared controls.
module tb_jk_counter_ctrl;

`ifdef JK_CTRL_AUTOSTOP_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 0, stop = 0, load = 0, clr = 0, dir = 1;
  logic [2:0] load_val = '0;

  logic [2:0] q8, j8, k8, q6, j6, k6;
  logic       busy8, tc8, done8, busy6, tc6, done6;

  always #5 CLK = ~CLK;

  jk_counter_ctrl #(.N(3), .MOD(8)) u8 (
    .CLK(CLK), .rst_n(rst_n), .start(start), .stop(stop),
    .load(load), .clr(clr), .dir(dir), .load_val(load_val),
    .Q_in(q8), .J(j8), .K(k8), .busy(busy8), .tc(tc8), .done(done8)
  );

  jk_counter_ctrl #(.N(3), .MOD(6)) u6 (
    .CLK(CLK), .rst_n(rst_n), .start(start), .stop(stop),
    .load(load), .clr(clr), .dir(dir), .load_val(load_val),
    .Q_in(q6), .J(j6), .K(k6), .busy(busy6), .tc(tc6), .done(done6)
  );

  // External JK flip-flop banks.
  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      q8 <= '0;
      q6 <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        case ({j8[i], k8[i]})
          2'b01: q8[i] <= 1'b0;
          2'b10: q8[i] <= 1'b1;
          2'b11: q8[i] <= ~q8[i];
          default: ;
        endcase
        case ({j6[i], k6[i]})
          2'b01: q6[i] <= 1'b0;
          2'b10: q6[i] <= 1'b1;
          2'b11: q6[i] <= ~q6[i];
          default: ;
        endcase
      end
    end
  end

  typedef struct {
    bit         sel;
    logic [2:0] q;
    logic       busy;
    logic       tc;
    logic       done;
    bit         cj;
    logic [2:0] j;
    logic [2:0] k;
  } exp_t;

  exp_t  exq[$];
  string nmq[$];
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic chk(string nm, string f, logic [7:0] act, logic [7:0] ex);
    n_chk++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0h required=%0h t=%0t",
               nm, f, act, ex, $time);
    end
  endtask

  exp_t  me;
  string mnm;

  // Monitor: compare every queued expectation at the falling edge.
  always @(negedge CLK) begin
    while (exq.size() != 0) begin
      me  = exq.pop_front();
      mnm = nmq.pop_front();
      if (me.sel == 1'b0) begin
        chk(mnm, "q", {5'd0, q8}, {5'd0, me.q});
        chk(mnm, "busy", {7'd0, busy8}, {7'd0, me.busy});
        chk(mnm, "tc", {7'd0, tc8}, {7'd0, me.tc});
        chk(mnm, "done", {7'd0, done8}, {7'd0, me.done});
        if (me.cj) begin
          chk(mnm, "J", {5'd0, j8}, {5'd0, me.j});
          chk(mnm, "K", {5'd0, k8}, {5'd0, me.k});
        end
      end else begin
        chk(mnm, "q", {5'd0, q6}, {5'd0, me.q});
        chk(mnm, "busy", {7'd0, busy6}, {7'd0, me.busy});
        chk(mnm, "tc", {7'd0, tc6}, {7'd0, me.tc});
        chk(mnm, "done", {7'd0, done6}, {7'd0, me.done});
        if (me.cj) begin
          chk(mnm, "J", {5'd0, j6}, {5'd0, me.j});
          chk(mnm, "K", {5'd0, k6}, {5'd0, me.k});
        end
      end
    end
  end

  task automatic expect_now(bit s, logic [2:0] q, logic b, logic t,
                            logic d, bit cj, logic [2:0] j,
                            logic [2:0] k, string nm);
    exp_t e;
    e.sel = s; e.q = q; e.busy = b; e.tc = t; e.done = d;
    e.cj = cj; e.j = j; e.k = k;
    exq.push_back(e);
    nmq.push_back(nm);
  endtask

  task automatic tick(bit s, logic [2:0] q, logic b, logic t, logic d,
                      string nm);
    @(posedge CLK);
    #1;
    expect_now(s, q, b, t, d, 1'b0, 3'd0, 3'd0, nm);
  endtask

  task automatic tick_jk(bit s, logic [2:0] q, logic b, logic t, logic d,
                         logic [2:0] j, logic [2:0] k, string nm);
    @(posedge CLK);
    #1;
    expect_now(s, q, b, t, d, 1'b1, j, k, nm);
  endtask

  task automatic do_reset(bit s, string nm);
    @(posedge CLK);
    #2;
    rst_n = 1'b0;
    start = 0; stop = 0; load = 0; clr = 0;
    #1;
    expect_now(s, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, nm);
    @(posedge CLK);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Up count MOD=8 through a full wrap.
    do_reset(0, "rst_a");
    dir = 1; start = 1;
    tick_jk(0, 3'd0, 1, 0, 0, 3'd1, 3'd0, "a_go");
    start = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 7)
        tick_jk(0, 3'd7, 1, 1, 0, 3'd0, 3'd7, "a_q7");
      else
        tick(0, 3'(i % 8), 1, 0, AUTO && (i == 8), $sformatf("a_s%0d", i));
    end
    tick(0, AUTO ? 3'd0 : 3'd1, !AUTO, 0, 0, "a_after");
    stop = 1;
    tick(0, AUTO ? 3'd0 : 3'd2, 0, 0, 0, "a_stop");
    stop = 0;
    tick_jk(0, AUTO ? 3'd0 : 3'd2, 0, 0, 0, 3'd0, 3'd0, "a_hold");

    // clr beats load and start in RUN.
    do_reset(0, "rst_b");
    dir = 1; start = 1;
    tick(0, 3'd0, 1, 0, 0, "b_go");
    start = 0;
    tick(0, 3'd1, 1, 0, 0, "b_q1");
    tick(0, 3'd2, 1, 0, 0, "b_q2");
    clr = 1; load = 1; start = 1; load_val = 3'd5;
    tick_jk(0, 3'd3, 1, 0, 0, 3'd0, 3'd7, "b_clr");
    clr = 0; load = 0; start = 0;
    tick(0, 3'd0, 0, 0, 0, "b_idle");
    tick_jk(0, 3'd0, 0, 0, 0, 3'd0, 3'd0, "b_hold");

    // Asynchronous reset mid-RUN at Q=3.
    start = 1;
    tick(0, 3'd0, 1, 0, 0, "c_go");
    start = 0;
    tick(0, 3'd1, 1, 0, 0, "c_q1");
    tick(0, 3'd2, 1, 0, 0, "c_q2");
    tick(0, 3'd3, 1, 0, 0, "c_q3");
    @(negedge CLK);
    #1;
    rst_n = 1'b0;
    #1;
    expect_now(0, 3'd0, 0, 0, 0, 1'b1, 3'd0, 3'd0, "c_async");
    @(posedge CLK);
    #2;
    rst_n = 1'b1;
    tick(0, 3'd0, 0, 0, 0, "c_rel1");
    tick(0, 3'd0, 0, 0, 0, "c_rel2");

    // Down count MOD=6 from 0.
    do_reset(1, "rst_d");
    dir = 0; start = 1;
    tick_jk(1, 3'd0, 1, 1, 0, 3'd5, 3'd0, "d_go");
    start = 0;
    if (AUTO) begin
      tick(1, 3'd5, 1, 0, 1, "d_done");
      tick(1, 3'd5, 0, 0, 0, "d_idle");
    end else begin
      tick(1, 3'd5, 1, 0, 0, "d_q5");
      tick(1, 3'd4, 1, 0, 0, "d_q4");
      tick(1, 3'd3, 1, 0, 0, "d_q3");
      tick(1, 3'd2, 1, 0, 0, "d_q2");
      tick(1, 3'd1, 1, 0, 0, "d_q1");
      tick(1, 3'd0, 1, 1, 0, "d_q0");
      tick(1, 3'd5, 1, 0, 0, "d_wrap");
      stop = 1;
      tick(1, 3'd4, 0, 0, 0, "d_stop");
      stop = 0;
    end

    // Loads at MOD=6, including an out-of-range value.
    do_reset(1, "rst_e");
    stop = 1;
    tick(1, 3'd0, 0, 0, 0, "e_stop_idle");
    stop = 0; load = 1; load_val = 3'd5;
    tick_jk(1, 3'd0, 1, 0, 0, 3'd5, 3'd2, "e_ld5");
    load = 0;
    tick(1, 3'd5, 0, 0, 0, "e_q5");
    tick(1, 3'd5, 0, 0, 0, "e_hold5");
    load = 1; load_val = 3'd7;
    tick_jk(1, 3'd5, 1, 0, 0, 3'd0, 3'd7, "e_ld7");
    load = 0;
    tick(1, 3'd0, 0, 0, 0, "e_q0");

    // Direction change mid-RUN at MOD=8.
    do_reset(0, "rst_f");
    dir = 1; start = 1;
    tick(0, 3'd0, 1, 0, 0, "f_go");
    start = 0;
    tick(0, 3'd1, 1, 0, 0, "f_q1");
    tick(0, 3'd2, 1, 0, 0, "f_q2");
    dir = 0;
    tick(0, 3'd1, 1, 0, 0, "f_dn1");
    tick_jk(0, 3'd0, 1, 1, 0, 3'd7, 3'd0, "f_dn0");
    stop = 1;
    tick(0, 3'd7, 0, 0, 0, "f_stop");
    stop = 0;

    repeat (2) @(negedge CLK);
    #1;
    n_chk++;
    if (exq.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d required=0", exq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
